throw_ctrl: RTL and testbench
=============================

THROW_CTRL -- requirements
Module: throw_ctrl

Interface
REQ-001 Parameter POWER_MAX, default 100, saturation value of charge power.
REQ-002 Parameter POWER_STEP, default 2, power increment per frame tick while charging.
REQ-003 Parameter FLIGHT_TIMEOUT, default 240, maximum flight length in frame ticks.
REQ-004 Parameter SETTLE_FRAMES, default 30, post-throw hold in frame ticks.
REQ-005 clk60MHz  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 turn  input  3  turn counter from the turn manager.
REQ-008 btn_throw  input  1  raw, asynchronous throw button; high means pressed.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 hit  input  1  collision pulse from physics.
REQ-011 out_of_bounds  input  1  projectile-left-screen pulse from physics.
REQ-012 current_player  output  2  active player code.
REQ-013 in_throw_flag  output  1  high while charging.
REQ-014 throw_flag  output  1  high while projectile in flight.
REQ-015 power  output  7  current/latched launch power.
REQ-016 launch  output  1  one-cycle pulse at launch.
REQ-017 result  output  2  last throw outcome: NONE, HIT or MISS.

Function
REQ-018 current_player SHALL be combinational from turn: PLAYER_1 when turn[0]=1, else PLAYER_2.
REQ-019 btn_throw SHALL pass a 2-flop synchronizer; press = rising edge of synchronized signal, release = falling edge.
REQ-020 FSM states: IDLE, CHARGE, FLIGHT, SETTLE.
REQ-021 IDLE: press -> CHARGE next cycle, power cleared to 0; release/ticks ignored.
REQ-022 CHARGE: in_throw_flag=1; on each frame_tick power += POWER_STEP, saturating at POWER_MAX (no wrap).
REQ-023 CHARGE: release -> FLIGHT next cycle; power latched and held; launch=1 for exactly that first FLIGHT cycle.
REQ-024 CHARGE->FLIGHT: in_throw_flag falls on the same edge throw_flag rises, so at least one flag is high every cycle from entry to CHARGE until exit from FLIGHT, and never both.
REQ-025 FLIGHT: throw_flag=1; flight counter increments on frame_tick.
REQ-026 FLIGHT exit -> SETTLE next cycle on hit (result=HIT), on out_of_bounds (result=MISS), or when the counter reaches FLIGHT_TIMEOUT (result=MISS).
REQ-027 If hit coincides with out_of_bounds or timeout in the same cycle, hit SHALL take priority (result=HIT).
REQ-028 SETTLE: both flags 0; after SETTLE_FRAMES frame_ticks -> IDLE.
REQ-029 Presses in FLIGHT/SETTLE SHALL be ignored; a button still held on return to IDLE SHALL NOT start a charge (a new press is required).
REQ-030 hit/out_of_bounds outside FLIGHT SHALL be ignored.
REQ-031 result SHALL hold until the next launch, then return to NONE.
REQ-032 Counters SHALL be sized for their parameter maximum, with no overflow.

Reset
REQ-033 On rst_n low: state=IDLE, power=0, launch=0, result=NONE, flags=0, counters=0, synchronizer flops=0; all asynchronously.
REQ-034 Reset asserted mid-CHARGE/FLIGHT SHALL abort the throw; after release the block waits in IDLE for a new press.

Structure
REQ-035 PLAYER_1/PLAYER_2 codes, the result encoding and the FSM state enum SHALL live in variable_pkg.
REQ-036 The synchronizer plus edge detector SHALL be a sub-module btn_sync (outputs press, release, level).
REQ-037 Parameters SHALL remain module-level.

Verification
REQ-038 Press, hold 10 ticks, release -> power=20, one launch pulse, in_throw_flag 1->0 and throw_flag 0->1 on the same edge.
REQ-039 Hold 80 ticks -> power saturates at 100 and stays at 100 at launch.
REQ-040 Launch, then pulse hit and out_of_bounds in the same cycle -> result=HIT, SETTLE, flags 0, IDLE after 30 ticks.
REQ-041 Launch, no events -> throw_flag falls after 240 ticks, result=MISS.
REQ-042 turn=3'b001 -> PLAYER_1; turn=3'b010 -> PLAYER_2; button held through SETTLE -> no new CHARGE.
REQ-043 rst_n low during FLIGHT -> flags 0, IDLE immediately, result=NONE.

Source files
------------

// File: rtl/variable_pkg.sv
// Shared encodings for the throw controller: player codes, throw outcome and FSM states,
// plus the saturating power adder used while charging.
package variable_pkg;

    localparam int POWER_W = 7;

    typedef enum logic [1:0] {
        PLAYER_NONE = 2'b00,
        PLAYER_1    = 2'b01,
        PLAYER_2    = 2'b10
    } player_e;

    typedef enum logic [1:0] {
        RESULT_NONE = 2'b00,
        RESULT_HIT  = 2'b01,
        RESULT_MISS = 2'b10
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHARGE = 2'b01,
        ST_FLIGHT = 2'b10,
        ST_SETTLE = 2'b11
    } state_e;

    // Sum is formed in int so the step can never wrap the 7-bit power value.
    function automatic logic [POWER_W-1:0] sat_add(input logic [POWER_W-1:0] value,
                                                   input int step,
                                                   input int limit);
        int sum;
        sum = int'(value) + step;
        if (sum > limit) begin
            return POWER_W'(limit);
        end
        return POWER_W'(sum);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchronizer for the raw throw button with rising/falling edge detection
// on the synchronized level.
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk60MHz,
    input  logic rst_n,
    input  logic btn_async,
    output logic press,
    output logic released,
    output logic level
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic              level_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = btn_async;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg    <= sync_next;
            level_d_reg <= sync_reg[STAGES-1];
        end
    end

    assign level    = sync_reg[STAGES-1];
    assign press    = level & ~level_d_reg;
    assign released = ~level & level_d_reg;

endmodule

// File: rtl/throw_ctrl.sv
// Throw sequencer: charge power while the button is held, launch on release, track the
// flight until hit/out-of-bounds/timeout, then hold for a settle period before re-arming.
module throw_ctrl
    import variable_pkg::*;
#(
    parameter int POWER_MAX      = 100,
    parameter int POWER_STEP     = 2,
    parameter int FLIGHT_TIMEOUT = 240,
    parameter int SETTLE_FRAMES  = 30
) (
    input  logic         clk60MHz,
    input  logic         rst_n,
    input  logic [2:0]   turn,
    input  logic         btn_throw,
    input  logic         frame_tick,
    input  logic         hit,
    input  logic         out_of_bounds,
    output logic [1:0]   current_player,
    output logic         in_throw_flag,
    output logic         throw_flag,
    output logic [POWER_W-1:0] power,
    output logic         launch,
    output logic [1:0]   result
);

    // One frame counter serves both FLIGHT and SETTLE, so it is sized for the larger limit.
    localparam int CNT_MAX = (FLIGHT_TIMEOUT > SETTLE_FRAMES) ? FLIGHT_TIMEOUT : SETTLE_FRAMES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLIGHT_LIMIT = CNT_W'(FLIGHT_TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_FRAMES);

    state_e             state_reg,  state_next;
    logic [POWER_W-1:0] power_reg,  power_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic               launch_reg, launch_next;
    result_e            result_reg, result_next;

    logic btn_press;
    logic btn_released;
    logic btn_level;
    logic unused_turn_bits;

    btn_sync #(
        .STAGES (2)
    ) u_btn_sync (
        .clk60MHz  (clk60MHz),
        .rst_n     (rst_n),
        .btn_async (btn_throw),
        .press     (btn_press),
        .released  (btn_released),
        .level     (btn_level)
    );

    // Only the parity of the turn counter selects the player.
    assign unused_turn_bits = ^{turn[2:1], btn_level};
    assign current_player   = turn[0] ? PLAYER_1 : PLAYER_2;

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            power_reg  <= '0;
            cnt_reg    <= '0;
            launch_reg <= 1'b0;
            result_reg <= RESULT_NONE;
        end else begin
            state_reg  <= state_next;
            power_reg  <= power_next;
            cnt_reg    <= cnt_next;
            launch_reg <= launch_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        power_next  = power_reg;
        cnt_next    = cnt_reg;
        launch_next = 1'b0;
        result_next = result_reg;

        case (state_reg)
            ST_IDLE: begin
                // Edge-triggered start: a button still held from an earlier throw never re-arms.
                if (btn_press) begin
                    state_next = ST_CHARGE;
                    power_next = '0;
                end
            end

            ST_CHARGE: begin
                if (frame_tick) begin
                    power_next = sat_add(power_reg, POWER_STEP, POWER_MAX);
                end
                if (btn_released) begin
                    state_next  = ST_FLIGHT;
                    launch_next = 1'b1;
                    result_next = RESULT_NONE;
                    cnt_next    = '0;
                end
            end

            ST_FLIGHT: begin
                // Hit is tested first so it wins over a coincident miss condition.
                if (hit) begin
                    state_next  = ST_SETTLE;
                    result_next = RESULT_HIT;
                    cnt_next    = '0;
                end else if (out_of_bounds || (cnt_reg == FLIGHT_LIMIT)) begin
                    state_next  = ST_SETTLE;
                    result_next = RESULT_MISS;
                    cnt_next    = '0;
                end else if (frame_tick && (cnt_reg < FLIGHT_LIMIT)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_reg == SETTLE_LIMIT) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (frame_tick) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign in_throw_flag = (state_reg == ST_CHARGE);
    assign throw_flag    = (state_reg == ST_FLIGHT);
    assign power         = power_reg;
    assign launch        = launch_reg;
    assign result        = result_reg;

endmodule

// File: tb/tb_throw_ctrl.sv
// Self-checking bench for throw_ctrl: scenario tasks plus randomized throws checked
// against throw-level expectations (ticks held -> power, event -> outcome, tick counts).
`timescale 1ns/1ps
module tb_throw_ctrl;
    import variable_pkg::*;

    localparam int P_MAX  = 100;
    localparam int P_STEP = 2;
    localparam int F_TO   = 240;
    localparam int S_FR   = 30;

    logic       clk60MHz = 1'b0;
    logic       rst_n;
    logic [2:0] turn;
    logic       btn_throw;
    logic       frame_tick;
    logic       hit;
    logic       out_of_bounds;
    logic [1:0] current_player;
    logic       in_throw_flag;
    logic       throw_flag;
    logic [6:0] power;
    logic       launch;
    logic [1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    int   launch_count  = 0;
    int   handoff_count = 0;
    logic both_seen     = 1'b0;
    logic prev_in       = 1'b0;
    logic prev_thr      = 1'b0;

    throw_ctrl #(
        .POWER_MAX      (P_MAX),
        .POWER_STEP     (P_STEP),
        .FLIGHT_TIMEOUT (F_TO),
        .SETTLE_FRAMES  (S_FR)
    ) dut (
        .clk60MHz       (clk60MHz),
        .rst_n          (rst_n),
        .turn           (turn),
        .btn_throw      (btn_throw),
        .frame_tick     (frame_tick),
        .hit            (hit),
        .out_of_bounds  (out_of_bounds),
        .current_player (current_player),
        .in_throw_flag  (in_throw_flag),
        .throw_flag     (throw_flag),
        .power          (power),
        .launch         (launch),
        .result         (result)
    );

    always #8 clk60MHz = ~clk60MHz;

    // Flag/launch observer on the falling edge.
    always @(negedge clk60MHz) begin
        if (in_throw_flag && throw_flag) both_seen <= 1'b1;
        if (launch) launch_count <= launch_count + 1;
        if (prev_in && !in_throw_flag && throw_flag && !prev_thr) handoff_count <= handoff_count + 1;
        prev_in  <= in_throw_flag;
        prev_thr <= throw_flag;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk60MHz);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic start_charge(output bit ok);
        btn_throw = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (in_throw_flag) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic charge_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic release_and_launch(output bit ok, output logic [6:0] pw, output logic lp);
        btn_throw = 1'b0;
        ok = 1'b0;
        pw = '0;
        lp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (throw_flag) begin
                ok = 1'b1;
                pw = power;
                lp = launch;
                return;
            end
        end
    endtask

    task automatic end_by_event(input bit do_hit, input bit do_oob);
        hit = do_hit;
        out_of_bounds = do_oob;
        step();
        hit = 1'b0;
        out_of_bounds = 1'b0;
    endtask

    task automatic ticks_until_flight_end(output int t);
        t = 0;
        while (t < 300) begin
            pulse_tick();
            step();
            t++;
            if (!throw_flag) return;
        end
        t = -1;
    endtask

    task automatic run_to_idle(output int t);
        t = 0;
        while (t < 100) begin
            pulse_tick();
            step();
            t++;
            if (dut.state_reg == ST_IDLE) return;
        end
        t = -1;
    endtask

    function automatic int exp_power(input int n);
        return (n * P_STEP > P_MAX) ? P_MAX : n * P_STEP;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; turn = 3'b000; btn_throw = 1'b0; frame_tick = 1'b0;
        hit = 1'b0; out_of_bounds = 1'b0;
        repeat (3) step();
        n_cmp++; if (in_throw_flag !== 1'b0) begin n_fail++; $display("FAIL reset_in_flag: got %b want 0", in_throw_flag); end
        n_cmp++; if (throw_flag !== 1'b0) begin n_fail++; $display("FAIL reset_throw_flag: got %b want 0", throw_flag); end
        n_cmp++; if (power !== 7'd0) begin n_fail++; $display("FAIL reset_power: got %0d want 0", power); end
        n_cmp++; if (launch !== 1'b0) begin n_fail++; $display("FAIL reset_launch: got %b want 0", launch); end
        n_cmp++; if (result !== RESULT_NONE) begin n_fail++; $display("FAIL reset_result: got %0d want %0d", result, RESULT_NONE); end
        rst_n = 1'b1;
        repeat (2) step();
        $display("reset: released");
    endtask

    task automatic test_player();
        logic [2:0] pat [2];
        logic [1:0] want;
        pat[0] = 3'b001;
        pat[1] = 3'b010;
        for (int i = 0; i < 8; i++) begin
            turn = (i < 2) ? pat[i] : 3'($urandom_range(0, 7));
            #1;
            want = turn[0] ? 2'b01 : 2'b10;
            n_cmp++; if (current_player !== want) begin n_fail++; $display("FAIL player: turn=%b got %b want %b", turn, current_player, want); end
            $display("player: turn=%b player=%b", turn, current_player);
        end
    endtask

    // Full launch with n ticks; checks entry, latched power, single launch and flag handoff.
    task automatic launch_throw(input string tag, input int n);
        bit ok;
        logic [6:0] pw;
        logic lp;
        int lc0, hc0;
        start_charge(ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_charge_entry: got %b want 1", tag, ok); end
        charge_ticks(n);
        lc0 = launch_count;
        hc0 = handoff_count;
        release_and_launch(ok, pw, lp);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_flight_entry: got %b want 1", tag, ok); end
        n_cmp++; if (pw !== 7'(exp_power(n))) begin n_fail++; $display("FAIL %s_power: got %0d want %0d", tag, pw, exp_power(n)); end
        n_cmp++; if (lp !== 1'b1) begin n_fail++; $display("FAIL %s_launch_pulse: got %b want 1", tag, lp); end
        n_cmp++; if (result !== RESULT_NONE) begin n_fail++; $display("FAIL %s_result_cleared: got %0d want 0", tag, result); end
        step();
        n_cmp++; if (launch !== 1'b0) begin n_fail++; $display("FAIL %s_launch_width: got %b want 0", tag, launch); end
        n_cmp++; if (launch_count - lc0 !== 1) begin n_fail++; $display("FAIL %s_launch_count: got %0d want 1", tag, launch_count - lc0); end
        n_cmp++; if (handoff_count - hc0 !== 1) begin n_fail++; $display("FAIL %s_flag_handoff: got %0d want 1", tag, handoff_count - hc0); end
        $display("throw %s: ticks=%0d power=%0d", tag, n, pw);
    endtask

    task automatic finish_and_settle(input string tag, input logic [1:0] want_res);
        int t;
        n_cmp++; if (throw_flag !== 1'b0 || in_throw_flag !== 1'b0) begin n_fail++; $display("FAIL %s_flags_settle: got %b%b want 00", tag, in_throw_flag, throw_flag); end
        n_cmp++; if (result !== want_res) begin n_fail++; $display("FAIL %s_result: got %0d want %0d", tag, result, want_res); end
        run_to_idle(t);
        n_cmp++; if (t !== S_FR) begin n_fail++; $display("FAIL %s_settle_ticks: got %0d want %0d", tag, t, S_FR); end
        $display("settle %s: result=%0d settle_ticks=%0d", tag, result, t);
    endtask

    task automatic test_charge_basic();
        launch_throw("basic", 10);
        end_by_event(1'b1, 1'b0);
        finish_and_settle("basic", RESULT_HIT);
    endtask

    task automatic test_saturate();
        bit ok;
        logic [6:0] pw;
        logic lp;
        start_charge(ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_charge_entry: got %b want 1", ok); end
        charge_ticks(50);
        n_cmp++; if (power !== 7'(P_MAX)) begin n_fail++; $display("FAIL sat_mid: got %0d want %0d", power, P_MAX); end
        charge_ticks(30);
        n_cmp++; if (power !== 7'(P_MAX)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", power, P_MAX); end
        release_and_launch(ok, pw, lp);
        n_cmp++; if (pw !== 7'(P_MAX) || lp !== 1'b1) begin n_fail++; $display("FAIL sat_launch: power %0d launch %b want %0d 1", pw, lp, P_MAX); end
        $display("throw sat: ticks=80 power=%0d", pw);
        repeat (3) pulse_tick();
        end_by_event(1'b0, 1'b1);
        finish_and_settle("sat", RESULT_MISS);
        n_cmp++; if (power !== 7'(P_MAX)) begin n_fail++; $display("FAIL sat_power_held: got %0d want %0d", power, P_MAX); end
    endtask

    task automatic test_hit_priority();
        launch_throw("prio", 5);
        repeat (4) pulse_tick();
        end_by_event(1'b1, 1'b1);
        finish_and_settle("prio", RESULT_HIT);
        // Stray physics pulses in IDLE must leave the outcome untouched.
        end_by_event(1'b0, 1'b1);
        end_by_event(1'b1, 1'b0);
        n_cmp++; if (result !== RESULT_HIT) begin n_fail++; $display("FAIL idle_events_ignored: got %0d want %0d", result, RESULT_HIT); end
    endtask

    task automatic test_timeout();
        int t;
        launch_throw("timeout", 3);
        ticks_until_flight_end(t);
        n_cmp++; if (t !== F_TO) begin n_fail++; $display("FAIL timeout_ticks: got %0d want %0d", t, F_TO); end
        $display("flight timeout: ticks=%0d", t);
        finish_and_settle("timeout", RESULT_MISS);
    endtask

    task automatic test_held_button();
        int t;
        bit saw;
        bit ok;
        launch_throw("held", 7);
        btn_throw = 1'b1;
        repeat (5) step();
        end_by_event(1'b1, 1'b0);
        n_cmp++; if (result !== RESULT_HIT) begin n_fail++; $display("FAIL held_result: got %0d want %0d", result, RESULT_HIT); end
        run_to_idle(t);
        n_cmp++; if (t !== S_FR) begin n_fail++; $display("FAIL held_settle_ticks: got %0d want %0d", t, S_FR); end
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (in_throw_flag) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL held_no_recharge: got %b want 0", saw); end
        btn_throw = 1'b0;
        repeat (4) step();
        start_charge(ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL held_new_press: got %b want 1", ok); end
        $display("held: recharge_while_held=%b new_press_ok=%b", saw, ok);
        btn_throw = 1'b0;
        repeat (4) step();
        end_by_event(1'b0, 1'b1);
        finish_and_settle("held2", RESULT_MISS);
    endtask

    task automatic test_reset_flight();
        bit saw;
        launch_throw("rst", 12);
        repeat (2) pulse_tick();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (throw_flag !== 1'b0 || in_throw_flag !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b want 00", in_throw_flag, throw_flag); end
        n_cmp++; if (result !== RESULT_NONE) begin n_fail++; $display("FAIL rst_result: got %0d want 0", result); end
        n_cmp++; if (power !== 7'd0) begin n_fail++; $display("FAIL rst_power: got %0d want 0", power); end
        n_cmp++; if (dut.state_reg !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
        step();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (in_throw_flag || throw_flag) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rst_stays_idle: got %b want 0", saw); end
        $display("reset mid-flight: state=%0d", dut.state_reg);
    endtask

    task automatic test_random_throws();
        int n, kind, t;
        logic [1:0] want;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 70);
            kind = $urandom_range(0, 3);
            launch_throw("rand", n);
            if (kind == 3) begin
                ticks_until_flight_end(t);
                n_cmp++; if (t !== F_TO) begin n_fail++; $display("FAIL rand_timeout_ticks: got %0d want %0d", t, F_TO); end
                want = RESULT_MISS;
            end else begin
                repeat ($urandom_range(0, 20)) pulse_tick();
                end_by_event(kind != 1, kind != 0);
                want = (kind == 1) ? RESULT_MISS : RESULT_HIT;
            end
            $display("rand %0d: kind=%0d ticks=%0d", it, kind, n);
            finish_and_settle("rand", want);
        end
    endtask

    initial begin
        test_reset();
        test_player();
        test_charge_basic();
        test_saturate();
        test_hit_priority();
        test_timeout();
        test_held_button();
        test_reset_flight();
        test_random_throws();
        n_cmp++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL flags_exclusive: both high seen=%b want 0", both_seen); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
